// File: rtl/exec_writeback_stage.sv
// ---------------------------------------------------------------------------
// exec_writeback_stage
//   Writeback stage that sits directly after the execute units. Entries
//   {result, flags, dst, wr_reg, wr_flags} arrive through a valid/ready
//   handshake and are held in a 2-entry skid buffer. Entries retire in order
//   to the register-file write port, and they update the architectural flags
//   register {overflow, sign, zero, carry}. A combinational forwarding lookup
//   returns the youngest buffered result that targets a given register.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   flush_i           synchronous clear of buffered entries (flags kept)
//   in_valid_i/_ready_o  input handshake; ready depends on occupancy only
//   result_i, flags_i, dst_i, wr_reg_i, wr_flags_i  incoming entry
//   rf_ready_i        register-file write port free this cycle
//   rf_we_o, rf_waddr_o, rf_wdata_o  register-file write port (from head)
//   flags_o           architectural flags register
//   fwd_addr_i        forwarding lookup address
//   fwd_hit_o, fwd_data_o  forwarding result (data is 0 when no hit)
// ---------------------------------------------------------------------------
module exec_writeback_stage #(
    parameter int W_OPR      = 16,
    parameter int W_FLAGS    = 4,
    parameter int W_REG_ADDR = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [W_OPR-1:0]      result_i,
    input  logic [W_FLAGS-1:0]    flags_i,
    input  logic [W_REG_ADDR-1:0] dst_i,
    input  logic                  wr_reg_i,
    input  logic                  wr_flags_i,
    input  logic                  rf_ready_i,
    output logic                  rf_we_o,
    output logic [W_REG_ADDR-1:0] rf_waddr_o,
    output logic [W_OPR-1:0]      rf_wdata_o,
    output logic [W_FLAGS-1:0]    flags_o,
    input  logic [W_REG_ADDR-1:0] fwd_addr_i,
    output logic                  fwd_hit_o,
    output logic [W_OPR-1:0]      fwd_data_o
);

    // Entry payload storage (no reset needed: validity comes from count_q)
    logic [W_OPR-1:0]      result_q   [2];
    logic [W_FLAGS-1:0]    eflags_q   [2];
    logic [W_REG_ADDR-1:0] dst_q      [2];
    logic                  wr_reg_q   [2];
    logic                  wr_flags_q [2];

    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q,  count_d;
    logic [W_FLAGS-1:0]    flags_q,  flags_d;

    logic                  head_valid_s;
    logic                  young_valid_s;
    logic                  young_idx_s;
    logic                  accept_s;
    logic                  retire_s;
    logic                  hit_old_s;
    logic                  hit_young_s;

    assign head_valid_s  = (count_q != 2'd0);
    // With two entries the younger one sits just behind the head.
    assign young_valid_s = (count_q == 2'd2);
    assign young_idx_s   = ~rd_ptr_q;

    assign in_ready_o = (count_q != 2'd2);
    assign accept_s   = in_valid_i & in_ready_o;
    // Flags-only entries never need the register-file port.
    assign retire_s   = head_valid_s & (rf_ready_i | ~wr_reg_q[rd_ptr_q]);

    // Register-file port driven straight from the head entry
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = {W_REG_ADDR{1'b0}};
        rf_wdata_o = {W_OPR{1'b0}};
        if (head_valid_s) begin
            rf_we_o    = wr_reg_q[rd_ptr_q] & rf_ready_i;
            rf_waddr_o = dst_q[rd_ptr_q];
            rf_wdata_o = result_q[rd_ptr_q];
        end else begin
            rf_we_o    = 1'b0;
        end
    end

    // Forwarding lookup: the younger entry takes priority over the head
    always_comb begin
        hit_old_s   = head_valid_s & wr_reg_q[rd_ptr_q] & (dst_q[rd_ptr_q] == fwd_addr_i);
        hit_young_s = young_valid_s & wr_reg_q[young_idx_s] & (dst_q[young_idx_s] == fwd_addr_i);
        fwd_hit_o   = hit_old_s | hit_young_s;
        if (hit_young_s) begin
            fwd_data_o = result_q[young_idx_s];
        end else if (hit_old_s) begin
            fwd_data_o = result_q[rd_ptr_q];
        end else begin
            fwd_data_o = {W_OPR{1'b0}};
        end
    end

    // Next-state for pointers, occupancy and the flags register
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flags_d  = flags_q;
        if (flush_i) begin
            // Accept and retire in the flush cycle are both dropped.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (accept_s) begin
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (retire_s) begin
                rd_ptr_d = ~rd_ptr_q;
                if (wr_flags_q[rd_ptr_q]) begin
                    flags_d = eflags_q[rd_ptr_q];
                end else begin
                    flags_d = flags_q;
                end
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({accept_s, retire_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            flags_q  <= {W_FLAGS{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    // Payload write into the tail slot on an accepted handshake
    always_ff @(posedge clk) begin
        if (accept_s && !flush_i) begin
            result_q[wr_ptr_q]   <= result_i;
            eflags_q[wr_ptr_q]   <= flags_i;
            dst_q[wr_ptr_q]      <= dst_i;
            wr_reg_q[wr_ptr_q]   <= wr_reg_i;
            wr_flags_q[wr_ptr_q] <= wr_flags_i;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
module tb_exec_writeback_stage;

    logic        clk, rst, flush, in_valid, in_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic [2:0]  dst;
    logic        wr_reg, wr_flags, rf_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  flags_out;
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    exec_writeback_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .result_i(result), .flags_i(flags), .dst_i(dst),
        .wr_reg_i(wr_reg), .wr_flags_i(wr_flags),
        .rf_ready_i(rf_ready), .rf_we_o(rf_we),
        .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .flags_o(flags_out), .fwd_addr_i(fwd_addr),
        .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-order queue of entries plus a flags register.
    typedef struct {
        logic [15:0] result;
        logic [3:0]  flags;
        logic [2:0]  dst;
        logic        wr_reg;
        logic        wr_flags;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] mflags;

    // Advance one clock: apply the model's rules at the edge, return at negedge.
    task automatic tick();
        bit acc, ret;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mflags = 4'b0000;
        end else begin
            acc = in_valid && (mq.size() < 2);
            ret = (mq.size() > 0) && (rf_ready || !mq[0].wr_reg);
            if (flush) begin
                mq.delete();
            end else begin
                if (ret) begin
                    e = mq.pop_front();
                    if (e.wr_flags) mflags = e.flags;
                end
                if (acc) begin
                    e.result = result; e.flags = flags; e.dst = dst;
                    e.wr_reg = wr_reg; e.wr_flags = wr_flags;
                    mq.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f,
                         input logic [2:0] d, input logic wr, input logic wf);
        in_valid = v; result = r; flags = f; dst = d; wr_reg = wr; wr_flags = wf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        n_cmp++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", flags_out); end
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL reset_fwd_hit got=%b exp=0", fwd_hit); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rf_ready = 1'b1;
        drive(1'b1, 16'h00F0, 4'b0000, 3'd3, 1'b1, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        fwd_addr = 3'd3;
        #1;
        n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL single_we got=%b exp=1", rf_we); end
        n_cmp++; if (rf_waddr !== 3'd3) begin n_err++; $display("FAIL single_waddr got=%0d exp=3", rf_waddr); end
        n_cmp++; if (rf_wdata !== 16'h00F0) begin n_err++; $display("FAIL single_wdata got=%h exp=00f0", rf_wdata); end
        tick();
        #1;
        n_cmp++; if (rf_we !== 1'b0 || fwd_hit !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL single_empty we=%b hit=%b rdy=%b exp 0/0/1", rf_we, fwd_hit, in_ready); end
        n_cmp++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL single_flags got=%b exp=0000", flags_out); end
    endtask

    task automatic test_back_to_back();
        rf_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 4'b0000, 3'd1, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hBBBB, 4'b0000, 3'd4, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hCCCC, 4'b0000, 3'd6, 1'b1, 1'b0);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
        tick();
        drive(1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        rf_ready = 1'b1;
        #1;
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd1, 16'hAAAA})
            begin n_err++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/1/aaaa", rf_we, rf_waddr, rf_wdata); end
        tick();
        #1;
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd4, 16'hBBBB})
            begin n_err++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/4/bbbb", rf_we, rf_waddr, rf_wdata); end
        tick();
        #1;
        n_cmp++; if (in_ready !== 1'b1 || rf_we !== 1'b0)
            begin n_err++; $display("FAIL b2b_drained rdy=%b we=%b exp 1/0 (C must not be written)", in_ready, rf_we); end
    endtask

    task automatic test_forward();
        rf_ready = 1'b0;
        drive(1'b1, 16'h1111, 4'b0000, 3'd2, 1'b1, 1'b0); tick();
        drive(1'b1, 16'h2222, 4'b0000, 3'd2, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        fwd_addr = 3'd2;
        #1;
        n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h2222)
            begin n_err++; $display("FAIL fwd_youngest hit=%b data=%h exp 1/2222", fwd_hit, fwd_data); end
        fwd_addr = 3'd5;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000)
            begin n_err++; $display("FAIL fwd_miss hit=%b data=%h exp 0/0000", fwd_hit, fwd_data); end
        flush = 1'b1; tick(); flush = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || rf_we !== 1'b0)
            begin n_err++; $display("FAIL flush_empty rdy=%b we=%b exp 1/0", in_ready, rf_we); end
    endtask

    task automatic test_flags_only();
        rf_ready = 1'b0;
        drive(1'b1, 16'h5A5A, 4'b0100, 3'd7, 1'b0, 1'b1); tick();
        drive(1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL flagsonly_we got=%b exp=0", rf_we); end
        tick();
        #1;
        n_cmp++; if (flags_out !== 4'b0100) begin n_err++; $display("FAIL flagsonly_flags got=%b exp=0100", flags_out); end
        n_cmp++; if (in_ready !== 1'b1 || rf_we !== 1'b0)
            begin n_err++; $display("FAIL flagsonly_empty rdy=%b we=%b exp 1/0", in_ready, rf_we); end
    endtask

    task automatic test_reset_full();
        int wrote = 0;
        rf_ready = 1'b0;
        drive(1'b1, 16'h6666, 4'b0000, 3'd6, 1'b1, 1'b0); tick();
        drive(1'b1, 16'h7777, 4'b0000, 3'd7, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        fwd_addr = 3'd6;
        #2;
        rst = 1'b1;
        mq.delete(); mflags = 4'b0000;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || rf_we !== 1'b0 || flags_out !== 4'b0000 || fwd_hit !== 1'b0)
            begin n_err++; $display("FAIL rst_full rdy=%b we=%b flags=%b hit=%b exp 1/0/0000/0", in_ready, rf_we, flags_out, fwd_hit); end
        tick();
        rst = 1'b0;
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rf_we === 1'b1) wrote++;
            tick();
        end
        n_cmp++; if (wrote !== 0) begin n_err++; $display("FAIL rst_full_no_write writes=%0d exp=0", wrote); end
    endtask

    task automatic test_random();
        logic        exp_we, exp_hit;
        logic [2:0]  exp_addr;
        logic [15:0] exp_data, exp_fdata;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom));
            rf_ready = $urandom_range(0, 2) != 0;
            flush    = $urandom_range(0, 29) == 0;
            fwd_addr = 3'($urandom);
            #1;
            exp_we = 1'b0; exp_addr = 3'd0; exp_data = 16'h0000;
            if (mq.size() > 0) begin
                exp_we = mq[0].wr_reg && rf_ready;
                exp_addr = mq[0].dst;
                exp_data = mq[0].result;
            end
            exp_hit = 1'b0; exp_fdata = 16'h0000;
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (!exp_hit && mq[k].wr_reg && mq[k].dst == fwd_addr) begin
                    exp_hit = 1'b1; exp_fdata = mq[k].result;
                end
            end
            n_cmp++; if (in_ready !== (mq.size() < 2))
                begin n_err++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, mq.size() < 2); end
            n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_addr, exp_data})
                begin n_err++; $display("FAIL rnd_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, exp_we, exp_addr, exp_data); end
            n_cmp++; if (flags_out !== mflags)
                begin n_err++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, flags_out, mflags); end
            n_cmp++; if (fwd_hit !== exp_hit || fwd_data !== exp_fdata)
                begin n_err++; $display("FAIL rnd_fwd c=%0d got=%b/%h exp=%b/%h", c, fwd_hit, fwd_data, exp_hit, exp_fdata); end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; rf_ready = 1'b0; fwd_addr = 3'd0;
        mflags = 4'b0000;
        drive(1'b0, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_forward();
        test_flags_only();
        test_reset_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
